instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/mips_pkg.sv | 29 ++
 rtl/if_id_reg.sv | 51 +++++
 rtl/instruction_fetch.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//   Shared definitions for the instruction fetch stage:
//   - XLEN           : datapath / address width
//   - PC_INC         : byte increment between sequential fetches
//   - NOP            : encoding placed in IF/ID when it is cleared
//   - fetch_state_t  : fetch FSM states (BOOT, RUN, HALTED)
//   - align_word()   : forces an address onto a 4-byte boundary
// ---------------------------------------------------------------------------
package mips_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] PC_INC    = 32'd4;
    localparam logic [XLEN-1:0] NOP       = 32'h0000_0000;
    localparam logic [XLEN-1:0] WORD_MASK = 32'h0000_0003;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // Instructions are word aligned; low address bits of a target are dropped.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~WORD_MASK;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
//   IF/ID pipeline register. Priority: clear > load > hold.
//   Ports:
//     clk, rst        : clock, asynchronous active-high reset
//     load            : capture next_instr / next_pc4 and mark valid
//     clear           : insert a bubble (valid=0, instr=NOP)
//     next_instr      : instruction word to capture
//     next_pc4        : fetch PC + 4 to capture
//     instr, pc4      : registered IF/ID contents
//     valid           : IF/ID holds a real instruction
// ---------------------------------------------------------------------------
module if_id_reg
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] next_instr,
    input  logic [XLEN-1:0] next_pc4,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc4,
    output logic            valid
);

    logic [XLEN-1:0] instr_reg;
    logic [XLEN-1:0] pc4_reg;
    logic            valid_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_reg <= NOP;
            pc4_reg   <= '0;
            valid_reg <= 1'b0;
        end else if (clear) begin
            instr_reg <= NOP;
            pc4_reg   <= '0;
            valid_reg <= 1'b0;
        end else if (load) begin
            instr_reg <= next_instr;
            pc4_reg   <= next_pc4;
            valid_reg <= 1'b1;
        end
    end

    assign instr = instr_reg;
    assign pc4   = pc4_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//   Fetch stage: owns the PC, drives the instruction memory address and
//   fills the IF/ID register. One bubble after every redirect.
//   Event priority inside RUN: halt, redirect, flush, stall, advance.
//   Parameters:
//     RESET_PC        : first fetch address after reset
//   Ports:
//     clk, rst        : clock, asynchronous active-high reset
//     pc_o            : fetch address to instruction memory
//     instr_i         : instruction memory data (combinational from pc_o)
//     stall_i         : hold request from decode
//     flush_i         : kill IF/ID contents
//     redirect_i      : taken branch / jump, target in redirect_pc_i
//     halt_i          : stop fetching until reset
//     if_id_instr_o   : IF/ID instruction
//     if_id_pc4_o     : IF/ID fetch PC + 4
//     if_id_valid_o   : IF/ID holds a real instruction
//     fetch_cnt_o     : instructions fetched
//     stall_cnt_o     : stalled cycles
//   Build option:
//     IF_PERF_CNT_EN  : when defined, fetch_cnt_o / stall_cnt_o count;
//                       otherwise both are tied to zero.
// ---------------------------------------------------------------------------
module instruction_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc_o,
    input  logic [31:0] instr_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        halt_i,
    output logic [31:0] if_id_instr_o,
    output logic [31:0] if_id_pc4_o,
    output logic        if_id_valid_o,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] stall_cnt_o
);

    fetch_state_t    state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic [XLEN-1:0] pc_plus4;
    logic            load_ifid;
    logic            clear_ifid;
    logic            stalled;

    // Addition wraps naturally at 2^32.
    assign pc_plus4 = pc_reg + PC_INC;

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        load_ifid  = 1'b0;
        clear_ifid = 1'b0;
        stalled    = 1'b0;
        case (state_reg)
            BOOT: begin
                // One settling cycle: no capture, PC untouched.
                if (halt_i) begin
                    state_next = HALTED;
                    clear_ifid = 1'b1;
                end else begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (halt_i) begin
                    state_next = HALTED;
                    clear_ifid = 1'b1;
                end else if (redirect_i) begin
                    // Redirect wins over stall: the stalled slot is dead anyway.
                    pc_next    = align_word(redirect_pc_i);
                    clear_ifid = 1'b1;
                end else if (flush_i) begin
                    clear_ifid = 1'b1;
                    if (!stall_i) begin
                        pc_next = pc_plus4;
                    end
                end else if (stall_i) begin
                    stalled = 1'b1;
                end else begin
                    load_ifid = 1'b1;
                    pc_next   = pc_plus4;
                end
            end
            HALTED: begin
                // Frozen until reset.
            end
            default: begin
                state_next = BOOT;
                pc_next    = RESET_PC;
                clear_ifid = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= BOOT;
            pc_reg    <= RESET_PC;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (load_ifid),
        .clear      (clear_ifid),
        .next_instr (instr_i),
        .next_pc4   (pc_plus4),
        .instr      (if_id_instr_o),
        .pc4        (if_id_pc4_o),
        .valid      (if_id_valid_o)
    );

    assign pc_o = pc_reg;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_reg;
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_reg <= '0;
            stall_cnt_reg <= '0;
        end else begin
            if (load_ifid) begin
                fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
            end
            if (stalled) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
        end
    end

    assign fetch_cnt_o = fetch_cnt_reg;
    assign stall_cnt_o = stall_cnt_reg;
`else
    logic unused_perf;
    assign unused_perf = stalled;
    assign fetch_cnt_o = '0;
    assign stall_cnt_o = '0;
`endif

endmodule
